// File: rtl/cpu_traffic_gen.sv
// LFSR pattern traffic generator on the SDRAM controller CPU port: write, read-verify or both over a word range.
// One bus cycle in flight; each access waits for enaWRreg&cpuena, and at least one idle slot separates accesses.
module cpu_traffic_gen #(
  parameter int ADDR_BITS = 26,
  parameter int LEN_BITS  = 16,
  parameter int ERR_BITS  = 8
) (
  input  logic                clk_114,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [ADDR_BITS:1]  base_addr,
  input  logic [LEN_BITS-1:0] length,
  input  logic [15:0]         seed,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ERR_BITS-1:0] err_count,
  output logic [ADDR_BITS:1]  err_addr,
  output logic [ADDR_BITS:1]  cpuAddr,
  output logic [3:0]          cpustate,
  output logic                cpuL,
  output logic                cpuU,
  output logic [15:0]         cpuWR,
  input  logic [15:0]         cpuRD,
  input  logic                enaWRreg,
  input  logic                cpuena
);
  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

  localparam logic [3:0]          CS_IDLE  = 4'b0101;
  localparam logic [ADDR_BITS:1]  ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [ERR_BITS-1:0] ERR_ONE  = {{(ERR_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_BITS:1]  base_q;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] remain;
  logic [15:0]         seed_q;
  logic                wr_pass;
  logic                verify_pass;
  logic                abort_pend;
  logic [15:0]         seed_eff;
  logic [15:0]         pat_next;
  logic                complete;
  logic                rd_mismatch;
  logic                stop_now;

  // cpuWR doubles as the pattern register; during read passes it holds the expected word.
  always_comb begin
    seed_eff    = (seed == 16'h0000) ? 16'h0001 : seed;
    pat_next    = {cpuWR[14:0], cpuWR[15] ^ cpuWR[13] ^ cpuWR[12] ^ cpuWR[10]};
    complete    = (state == ACCESS) && enaWRreg && cpuena;
    rd_mismatch = !wr_pass && (cpuRD != cpuWR);
    stop_now    = abort || abort_pend;
  end

  always_ff @(posedge clk_114) begin
    if (reset) begin
      state       <= IDLE;
      cpustate    <= CS_IDLE;
      cpuL        <= 1'b1;
      cpuU        <= 1'b1;
      cpuAddr     <= '0;
      cpuWR       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err_count   <= '0;
      err_addr    <= '0;
      base_q      <= '0;
      len_q       <= '0;
      remain      <= '0;
      seed_q      <= '0;
      wr_pass     <= 1'b0;
      verify_pass <= 1'b0;
      abort_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count   <= '0;
            err_addr    <= '0;
            aborted     <= 1'b0;
            abort_pend  <= 1'b0;
            base_q      <= base_addr;
            len_q       <= length;
            seed_q      <= seed_eff;
            cpuAddr     <= base_addr;
            cpuWR       <= seed_eff;
            remain      <= length;
            wr_pass     <= (mode != 2'b01);
            verify_pass <= mode[1];
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCESS;
              busy     <= 1'b1;
              cpustate <= {3'b001, (mode != 2'b01)};
              cpuL     <= 1'b0;
              cpuU     <= 1'b0;
            end
          end
        end
        ACCESS: begin
          // Abort never truncates a bus cycle; it is remembered until completion.
          if (abort) abort_pend <= 1'b1;
          if (complete) begin
            cpustate <= CS_IDLE;
            cpuL     <= 1'b1;
            cpuU     <= 1'b1;
            if (rd_mismatch) begin
              if (err_count != '1) err_count <= err_count + ERR_ONE;
              if (err_count == '0) err_addr <= cpuAddr;
            end
            if (stop_now) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= 1'b1;
            end else if (remain != LEN_ONE) begin
              state   <= GAP;
              cpuAddr <= cpuAddr + ADDR_ONE;
              cpuWR   <= pat_next;
              remain  <= remain - LEN_ONE;
            end else if (wr_pass && verify_pass) begin
              state   <= GAP;
              cpuAddr <= base_q;
              cpuWR   <= seed_q;
              remain  <= len_q;
              wr_pass <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (enaWRreg) begin
            state    <= ACCESS;
            cpustate <= {3'b001, wr_pass};
            cpuL     <= 1'b0;
            cpuU     <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
